// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_arbiter_pkg
//   Shared definitions for the VGA framebuffer path:
//   - fb_state_e : arbiter FSM state encoding (ST_IDLE / ST_FETCH / ST_DRAIN)
//   - 800x600@60 timing constants, shared with the timing generator
//   - fetch_cycles() : number of FETCH cycles for one line, with or without
//     reserved host slots
package vga_fb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  // 800x600@60 (40 MHz pixel clock)
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Every period-th FETCH cycle is given to the host when slots are enabled,
  // so words-1 further reads need (words-1)/(period-1) extra cycles.
  function automatic int fetch_cycles(input int words, input int period, input bit slot_en);
    if (slot_en && period > 1) return words + (words - 1) / (period - 1);
    return words;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if
//   Host single-word write port (valid/ready).
//   valid : host has a write pending
//   addr  : framebuffer word address
//   data  : framebuffer write data
//   ready : arbiter accepts the write in this cycle when valid & ready
//   Modports: master = host side, slave = arbiter side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/vga_fb_fetch_ctr.sv
// vga_fb_fetch_ctr
//   Word counter for one line fetch plus the host-slot divider.
//   i_clock  : pixel clock
//   i_reset  : synchronous active-high reset
//   i_run    : high while the arbiter is in FETCH; low clears the counters
//   o_k      : index of the word to read this cycle
//   o_slot   : this FETCH cycle is reserved for the host (no read issued)
//   o_last   : the read of word WORDS_PER_LINE-1 is issued this cycle
module vga_fb_fetch_ctr
  import vga_fb_arbiter_pkg::*;
#(
  parameter int WORDS_PER_LINE   = 50,
  parameter int LB_ADDR_W        = 6,
  parameter int HOST_SLOT_PERIOD = 4,
  parameter bit SLOT_EN          = 1'b0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_run,
  output logic [LB_ADDR_W-1:0] o_k,
  output logic                 o_slot,
  output logic                 o_last
);

  localparam int DIV_W = (HOST_SLOT_PERIOD > 1) ? $clog2(HOST_SLOT_PERIOD) : 1;

  logic [LB_ADDR_W-1:0] k_reg;
  logic [DIV_W-1:0]     div_reg;
  logic                 div_wrap;

  assign div_wrap = (div_reg == DIV_W'(HOST_SLOT_PERIOD - 1));
  // With slots disabled the divider still counts but never gates anything.
  assign o_slot   = SLOT_EN && i_run && div_wrap;
  assign o_last   = i_run && !o_slot && (k_reg == LB_ADDR_W'(WORDS_PER_LINE - 1));
  assign o_k      = k_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_run) begin
      k_reg   <= '0;
      div_reg <= '0;
    end else begin
      div_reg <= div_wrap ? '0 : div_reg + 1'b1;
      if (!o_slot) k_reg <= k_reg + 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port framebuffer RAM between line scanout and host writes.
//   A line request burst-reads WORDS_PER_LINE words into the ping-pong line
//   buffer; in IDLE the host port owns the RAM.
//   Optional feature macro: VGA_FB_ARB_HOST_SLOT_EN -- reserves every
//   HOST_SLOT_PERIOD-th FETCH cycle for the host.
// Ports
//   i_clock, i_reset     : pixel clock, synchronous active-high reset
//   i_frame_start        : rewind line pointer to 0
//   i_line_req           : fetch next line
//   host (slave)         : host write port valid/addr/data/ready
//   o_mem_addr/wdata/we  : RAM control; i_mem_rdata valid 1 cycle after addr
//   o_lb_we/addr/data    : line-buffer write
//   o_lb_bank            : bank being filled (scanout reads ~o_lb_bank)
//   o_line_done          : line completely written
//   o_overrun            : sticky, line request arrived while busy
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int ADDR_W           = 15,
  parameter int DATA_W           = 16,
  parameter int WORDS_PER_LINE   = 50,
  parameter int LB_ADDR_W        = 6,
  parameter int HOST_SLOT_PERIOD = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_frame_start,
  input  logic                 i_line_req,
  vga_fb_arbiter_if.slave      host,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  output logic                 o_mem_we,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_lb_we,
  output logic [LB_ADDR_W-1:0] o_lb_addr,
  output logic [DATA_W-1:0]    o_lb_data,
  output logic                 o_lb_bank,
  output logic                 o_line_done,
  output logic                 o_overrun
);

`ifdef VGA_FB_ARB_HOST_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  fb_state_e            state_reg;
  logic [ADDR_W-1:0]    ptr_reg;     // base of the next line to fetch
  logic [ADDR_W-1:0]    base_reg;    // base of the line in flight
  logic                 lb_we_reg;
  logic [LB_ADDR_W-1:0] lb_addr_reg;
  logic                 bank_reg;
  logic                 overrun_reg;

  logic [LB_ADDR_W-1:0] k;
  logic                 slot;
  logic                 last;
  logic                 fetch_rd;
  logic                 host_ready;
  logic                 host_fire;

  vga_fb_fetch_ctr #(
    .WORDS_PER_LINE   (WORDS_PER_LINE),
    .LB_ADDR_W        (LB_ADDR_W),
    .HOST_SLOT_PERIOD (HOST_SLOT_PERIOD),
    .SLOT_EN          (SLOT_EN)
  ) u_fetch_ctr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_run   (state_reg == ST_FETCH),
    .o_k     (k),
    .o_slot  (slot),
    .o_last  (last)
  );

  assign fetch_rd   = (state_reg == ST_FETCH) && !slot;
  // A line request in IDLE takes the RAM next cycle, so it wins the tie.
  assign host_ready = !i_reset &&
                      (((state_reg == ST_IDLE) && !i_line_req) ||
                       ((state_reg == ST_FETCH) && slot));
  assign host_fire  = host.valid && host_ready;
  assign host.ready = host_ready;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    if (fetch_rd) begin
      o_mem_addr = base_reg + ADDR_W'(k);
    end else if (host_fire) begin
      o_mem_addr  = host.addr;
      o_mem_wdata = host.data;
      o_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      base_reg    <= '0;
      lb_we_reg   <= 1'b0;
      lb_addr_reg <= '0;
      bank_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      // Read data returns one cycle after the address, so the line-buffer
      // write trails each read by one cycle.
      lb_we_reg <= fetch_rd;
      if (fetch_rd) lb_addr_reg <= k;

      if (i_line_req && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (i_line_req) begin
            state_reg <= ST_FETCH;
            base_reg  <= i_frame_start ? '0 : ptr_reg;
          end
        end
        ST_FETCH: begin
          if (last) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state_reg <= ST_IDLE;
          bank_reg  <= ~bank_reg;
          ptr_reg   <= ptr_reg + ADDR_W'(WORDS_PER_LINE);
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Rewind overrides the DRAIN increment; base_reg of a fetch in flight
      // is untouched.
      if (i_frame_start) ptr_reg <= '0;
    end
  end

  assign o_lb_we     = lb_we_reg;
  assign o_lb_addr   = lb_addr_reg;
  assign o_lb_data   = i_mem_rdata;
  assign o_lb_bank   = bank_reg;
  assign o_line_done = (state_reg == ST_DRAIN);
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Scoreboard bench: stimulus pushes expected line-buffer writes, line_done
//   pulses and RAM writes (with their cycle numbers); a negedge monitor pops
//   and compares whenever the DUT strobes one of them.
module tb_vga_fb_arbiter;
  import vga_fb_arbiter_pkg::*;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int W         = 50;
  localparam int LB_ADDR_W = 6;
  localparam int P         = 4;
`ifdef VGA_FB_ARB_HOST_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  typedef struct {
    int                   cyc;
    logic [LB_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } lb_exp_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, frame_start, line_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata, mem_rdata, lb_data;
  logic                 mem_we, lb_we, lb_bank, line_done, overrun;
  logic [LB_ADDR_W-1:0] lb_addr;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(W),
    .LB_ADDR_W(LB_ADDR_W), .HOST_SLOT_PERIOD(P)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_frame_start(frame_start), .i_line_req(line_req),
    .host(host_if),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .i_mem_rdata(mem_rdata),
    .o_lb_we(lb_we), .o_lb_addr(lb_addr), .o_lb_data(lb_data), .o_lb_bank(lb_bank),
    .o_line_done(line_done), .o_overrun(overrun)
  );

  // RAM model: injective address -> data pattern, one cycle read latency.
  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {1'b1, a} ^ 16'h5A5A;
  endfunction
  always @(posedge clk) mem_rdata <= ram_word(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lb_exp_t lb_q[$];
  int      done_q[$];
  wr_exp_t wr_q[$];
  int      checks = 0;
  int      failures = 0;
  int      fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cyc %0d)", name, act, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected schedule for a line requested during cycle c_req: read of word
  // k in FETCH cycle c lands in the line buffer at c_req+2+c. Entries later
  // than last_cyc are not pushed (used when reset cuts a fetch short).
  task automatic push_line(input int c_req, input logic [ADDR_W-1:0] base, input int last_cyc);
    lb_exp_t e;
    int k = 0;
    int c = 0;
    while (k < W) begin
      if (!(SLOT_EN && ((c % P) == P - 1))) begin
        if (c_req + 2 + c <= last_cyc) begin
          e.cyc  = c_req + 2 + c;
          e.addr = LB_ADDR_W'(k);
          e.data = ram_word(base + ADDR_W'(k));
          lb_q.push_back(e);
        end
        k++;
      end
      c++;
    end
    if (c_req + 1 + c <= last_cyc) done_q.push_back(c_req + 1 + c);
  endtask

  task automatic run_line(input logic [ADDR_W-1:0] base, input logic exp_bank, input string tag);
    push_line(cyc, base, 1 << 30);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
    repeat (fc + 1) tick();
    check({tag, "_bank"}, 32'(lb_bank), 32'(exp_bank));
  endtask

  always @(negedge clk) begin : monitor
    lb_exp_t e;
    wr_exp_t w;
    int      d;
    if (lb_we === 1'b1) begin
      if (lb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL lb_unexpected: write addr %0d at cyc %0d, required none", lb_addr, cyc);
      end else begin
        e = lb_q.pop_front();
        check("lb_cyc", cyc, e.cyc);
        check("lb_addr", 32'(lb_addr), 32'(e.addr));
        check("lb_data", 32'(lb_data), 32'(e.data));
      end
    end
    if (line_done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: line_done at cyc %0d, required none", cyc);
      end else begin
        d = done_q.pop_front();
        check("done_cyc", cyc, d);
      end
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: mem write addr %0h at cyc %0d, required none", mem_addr, cyc);
      end else begin
        w = wr_q.pop_front();
        check("wr_cyc", cyc, w.cyc);
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    wr_exp_t w;
    int c0;
    fc = fetch_cycles(W, P, SLOT_EN);
    rst = 1'b1; frame_start = 1'b0; line_req = 1'b0;
    host_if.valid = 1'b0; host_if.addr = '0; host_if.data = '0;

    // Reset state
    repeat (3) tick();
    check("rst_lb_we", 32'(lb_we), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_bank", 32'(lb_bank), 0);
    check("rst_ready", 32'(host_if.ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_done", 32'(line_done), 0);
    check("rst_lb_addr", 32'(lb_addr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    tick();
    check("ready_idle", 32'(host_if.ready), 1);

    // Reset held 3 cycles in the middle of a fetch
    c0 = cyc;
    push_line(c0, '0, c0 + 9);
    line_req = 1'b1; tick(); line_req = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("midrst_lb_we", 32'(lb_we), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_bank", 32'(lb_bank), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midrst_ready", 32'(host_if.ready), 1);
    check("midrst_lb_we_after", 32'(lb_we), 0);
    check("midrst_flush", lb_q.size(), 0);

    // frame_start then three lines: 0.., 50.., rewind -> 0..
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_line(15'd0, 1'b1, "line0");
    run_line(15'd50, 1'b0, "line1");
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_line(15'd0, 1'b1, "line2");

    // Host write in IDLE
    host_if.valid = 1'b1; host_if.addr = 15'h1234; host_if.data = 16'hBEEF;
    w.cyc = cyc; w.addr = 15'h1234; w.data = 16'hBEEF;
    wr_q.push_back(w);
    @(negedge clk);
    check("host_ready_idle", 32'(host_if.ready), 1);
    tick();
    host_if.valid = 1'b0;

    // Host write colliding with line_req: line wins, no RAM write
    host_if.valid = 1'b1; host_if.addr = 15'h0777; host_if.data = 16'h1357;
    push_line(cyc, 15'd50, 1 << 30);
    line_req = 1'b1;
    @(negedge clk);
    check("host_ready_tie", 32'(host_if.ready), 0);
    tick();
    line_req = 1'b0; host_if.valid = 1'b0;
    repeat (fc + 1) tick();
    check("tie_bank", 32'(lb_bank), 0);

    // line_req during FETCH: overrun, fetch unchanged, no extra line
    push_line(cyc, 15'd100, 1 << 30);
    line_req = 1'b1; tick(); line_req = 1'b0;
    repeat (4) tick();
    line_req = 1'b1; tick(); line_req = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    repeat (fc - 4) tick();
    check("ovr_bank", 32'(lb_bank), 1);
    repeat (6) tick();
    check("overrun_sticky", 32'(overrun), 1);
    check("ovr_idle_ready", 32'(host_if.ready), 1);

`ifdef VGA_FB_ARB_HOST_SLOT_EN
    // Host held valid through a fetch: accepted in the first slot (cycle 3)
    c0 = cyc;
    push_line(c0, 15'd150, 1 << 30);
    w.cyc = c0 + 4; w.addr = 15'h0ABC; w.data = 16'hC0DE;
    wr_q.push_back(w);
    line_req = 1'b1; tick(); line_req = 1'b0;
    host_if.valid = 1'b1; host_if.addr = 15'h0ABC; host_if.data = 16'hC0DE;
    repeat (3) tick();
    @(negedge clk);
    check("slot_ready", 32'(host_if.ready), 1);
    tick();
    host_if.valid = 1'b0;
    repeat (fc - 3) tick();
    check("slot_bank", 32'(lb_bank), 0);
`endif

    repeat (3) tick();
    check("lb_q_empty", lb_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
